// File: rtl/alu_exec_pipe_if.sv
// ALU command interface: the issuer sends {op1, op2, mode, opsel}, the unit returns {result, flags, err}.
// Latency: none; this is wiring only.
// Backpressure: valid/ready in both directions (in_valid/in_ready toward the unit, out_valid/out_ready back).
// Ports: in_valid, in_ready, op1, op2, opsel, mode, out_valid, out_ready, result, c_flag, z_flag, o_flag, s_flag, err.
// The master modport is the issuer and the slave modport is the execution unit.
interface alu_exec_pipe_if #(
   parameter int DWIDTH = 32
) ();
   logic              in_valid;
   logic              in_ready;
   logic [DWIDTH-1:0] op1;
   logic [DWIDTH-1:0] op2;
   logic [2:0]        opsel;
   logic              mode;
   logic              out_valid;
   logic              out_ready;
   logic [DWIDTH-1:0] result;
   logic              c_flag;
   logic              z_flag;
   logic              o_flag;
   logic              s_flag;
   logic              err;

   modport master (
      output in_valid, op1, op2, opsel, mode, out_ready,
      input  in_ready, out_valid, result, c_flag, z_flag, o_flag, s_flag, err
   );

   modport slave (
      input  in_valid, op1, op2, opsel, mode, out_ready,
      output in_ready, out_valid, result, c_flag, z_flag, o_flag, s_flag, err
   );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage pipelined ALU execution unit. S1 registers the command and S2 computes and registers the result and flags.
// Latency: out_valid rises 2 cycles after acceptance. Throughput is 1 op/cycle.
// Backpressure: a stalled output holds S2 and then S1. in_ready is low only while S1 is full and S2 cannot advance.
// Ports: clk, rst (synchronous, active high), bus (alu_exec_pipe_if.slave carrying the command and result handshakes).
module alu_exec_pipe #(
   parameter int DWIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   alu_exec_pipe_if.slave bus
);
   localparam int SHW = $clog2(DWIDTH);
   localparam int MSB = DWIDTH - 1;
   localparam logic [DWIDTH:0]   ONE_W   = {{DWIDTH{1'b0}}, 1'b1};
   localparam logic [DWIDTH-1:0] MAX_POS = {1'b0, {(DWIDTH-1){1'b1}}};
   localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

   typedef struct packed {
      logic [DWIDTH-1:0] op1;
      logic [DWIDTH-1:0] op2;
      logic [3:0]        opcode;   // {mode, opsel}
   } cmd_t;

   cmd_t  s1_cmd;
   logic  s1_valid;
   logic  carry_q;
   logic  s2_en;
   logic  s1_en;

   logic [DWIDTH-1:0] a;
   logic [DWIDTH-1:0] b;
   logic [SHW-1:0]    shamt;
   logic [DWIDTH:0]   wide;
   logic [DWIDTH-1:0] r_nxt;
   logic              c_nxt;
   logic              o_nxt;
   logic              err_nxt;

   assign s2_en       = !bus.out_valid || bus.out_ready;
   assign s1_en       = !s1_valid || s2_en;
   assign bus.in_ready = s1_en;

   // S2 datapath. Arithmetic runs in DWIDTH+1 bits so that the top bit is the carry or borrow.
   always_comb begin
      a       = s1_cmd.op1;
      b       = s1_cmd.op2;
      shamt   = b[SHW-1:0];
      wide    = '0;
      r_nxt   = '0;
      c_nxt   = 1'b0;
      o_nxt   = 1'b0;
      err_nxt = 1'b0;
      case (s1_cmd.opcode)
         4'h0: begin   // add
            wide  = {1'b0, a} + {1'b0, b};
            r_nxt = wide[MSB:0];
            c_nxt = wide[DWIDTH];
            o_nxt = (a[MSB] == b[MSB]) && (r_nxt[MSB] != a[MSB]);
         end
         4'h1: begin   // subwb: the borrow-in is the carry of the previous legal op
            wide  = {1'b0, a} - {1'b0, b} - {{DWIDTH{1'b0}}, carry_q};
            r_nxt = wide[MSB:0];
            c_nxt = wide[DWIDTH];
            o_nxt = (a[MSB] != b[MSB]) && (r_nxt[MSB] != a[MSB]);
         end
         4'h2: r_nxt = a;   // mov
         4'h3: begin   // sub
            wide  = {1'b0, a} - {1'b0, b};
            r_nxt = wide[MSB:0];
            c_nxt = wide[DWIDTH];
            o_nxt = (a[MSB] != b[MSB]) && (r_nxt[MSB] != a[MSB]);
         end
         4'h4: begin   // inc
            wide  = {1'b0, a} + ONE_W;
            r_nxt = wide[MSB:0];
            c_nxt = wide[DWIDTH];
            o_nxt = (a == MAX_POS);
         end
         4'h5: begin   // dec
            wide  = {1'b0, a} - ONE_W;
            r_nxt = wide[MSB:0];
            c_nxt = wide[DWIDTH];
            o_nxt = (a == MIN_NEG);
         end
         4'h6: begin   // addinc
            wide  = {1'b0, a} + {1'b0, b} + ONE_W;
            r_nxt = wide[MSB:0];
            c_nxt = wide[DWIDTH];
            o_nxt = (a[MSB] == b[MSB]) && (r_nxt[MSB] != a[MSB]);
         end
         4'h8: r_nxt = a & b;
         4'h9: r_nxt = a | b;
         4'hA: r_nxt = a ^ b;
         4'hB: r_nxt = ~a;
         4'hD: begin   // lshl: the bit shifted out lands in wide[DWIDTH], which is a[DWIDTH-shamt] and 0 for shamt==0
            wide  = {1'b0, a} << shamt;
            r_nxt = wide[MSB:0];
            c_nxt = wide[DWIDTH];
         end
         default: err_nxt = 1'b1;   // 7, C, E, F
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_cmd        <= '0;
         carry_q       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.c_flag    <= 1'b0;
         bus.z_flag    <= 1'b0;
         bus.o_flag    <= 1'b0;
         bus.s_flag    <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_cmd <= '{op1: bus.op1, op2: bus.op2, opcode: {bus.mode, bus.opsel}};
            end
         end
         if (s2_en) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
               bus.result <= r_nxt;
               bus.c_flag <= c_nxt;
               bus.o_flag <= o_nxt;
               bus.z_flag <= !err_nxt && (r_nxt == '0);
               bus.s_flag <= r_nxt[MSB];
               bus.err    <= err_nxt;
               // An illegal op leaves the carry chain untouched.
               if (!err_nxt) begin
                  carry_q <= c_nxt;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_exec_pipe.sv
module tb_alu_exec_pipe;
   localparam int DW = 32;

   logic clk;
   logic rst;
   alu_exec_pipe_if #(.DWIDTH(DW)) bif ();

   alu_exec_pipe #(.DWIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        o;
      logic        s;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   accept_cnt = 0;
   int   rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random
   bit   mc = 1'b0;      // the model's carry from the last legal op in program order

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   // Reference model taken straight from the opcode table, using 64-bit integer arithmetic.
   function automatic exp_t model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua = {32'h0, a};
      longint unsigned ub = {32'h0, b};
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned t  = 0;
      longint          st = 0;
      longint unsigned ci = {63'h0, mc};
      bit              arith = 1'b0;
      bit              cy = 1'b0;
      exp_t            e = '0;
      case (opc)
         4'h0: begin t = ua + ub;      st = sa + sb;             cy = t[32];          arith = 1; end
         4'h1: begin t = ua - ub - ci; st = sa - sb - longint'(ci); cy = (ua < ub + ci); arith = 1; end
         4'h2: t = ua;
         4'h3: begin t = ua - ub;      st = sa - sb;             cy = (ua < ub);      arith = 1; end
         4'h4: begin t = ua + 1;       st = sa + 1;              cy = t[32];          arith = 1; end
         4'h5: begin t = ua - 1;       st = sa - 1;              cy = (ua == 0);      arith = 1; end
         4'h6: begin t = ua + ub + 1;  st = sa + sb + 1;         cy = t[32];          arith = 1; end
         4'h8: t = ua & ub;
         4'h9: t = ua | ub;
         4'hA: t = ua ^ ub;
         4'hB: t = ~ua;
         4'hD: begin t = ua << b[4:0]; cy = t[32]; end
         default: begin
            e.e = 1'b1;
            return e;
         end
      endcase
      e.r = t[31:0];
      e.c = cy;
      e.o = arith && (st > 64'sd2147483647 || st < -64'sd2147483648);
      e.z = (e.r == 32'h0);
      e.s = e.r[31];
      mc  = cy;
      return e;
   endfunction

   // The interface presents the command, waits for in_ready and books the expected response on acceptance.
   task automatic issue(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      bif.in_valid = 1'b1;
      bif.op1 = a;
      bif.op2 = b;
      {bif.mode, bif.opsel} = opc;
      forever begin
         @(negedge clk);
         if (bif.in_ready) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 64'd0, 64'd1);
            break;
         end
      end
      if (n <= 200) begin
         exp_q.push_back(model(opc, a, b));
         accept_cnt++;
      end
      @(posedge clk);
      #1;
      bif.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   // Sole driver of out_ready.
   initial begin
      bif.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: bif.out_ready = 1'b0;
            1: bif.out_ready = 1'b1;
            default: bif.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pop and compare on every output handshake, and check that a stalled output stays stable.
   exp_t got_s;
   exp_t prev_s;
   bit   prev_stall = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         got_s = '{bif.result, bif.c_flag, bif.z_flag, bif.o_flag, bif.s_flag, bif.err};
         if (!rst) begin
            if (prev_stall) begin
               chk("stall_valid_held", {63'h0, bif.out_valid}, 64'd1);
               chk("stall_output_held", {27'h0, got_s}, {27'h0, prev_s});
            end
            if (bif.out_valid && bif.out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", {27'h0, got_s}, 64'd0);
               end else begin
                  chk("result_flags", {27'h0, got_s}, {27'h0, exp_q.pop_front()});
               end
            end
         end
         prev_stall = !rst && bif.out_valid && !bif.out_ready;
         prev_s     = got_s;
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b1;
      bif.in_valid = 1'b0;
      bif.op1 = '0;
      bif.op2 = '0;
      bif.opsel = '0;
      bif.mode = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {63'h0, bif.in_ready}, 64'd1);
      chk("rst_out_valid", {63'h0, bif.out_valid}, 64'd0);
      chk("rst_outputs", {26'h0, bif.result, bif.c_flag, bif.z_flag, bif.o_flag, bif.s_flag, bif.err}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First op: check the 2-cycle latency and the spec vector directly.
      issue(4'h0, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk);
      chk("latency_1cyc_not_valid", {63'h0, bif.out_valid}, 64'd0);
      @(negedge clk);
      chk("latency_2cyc_valid", {63'h0, bif.out_valid}, 64'd1);
      chk("add_wrap_vec", {27'h0, bif.result, bif.c_flag, bif.z_flag, bif.o_flag, bif.s_flag, bif.err},
          {27'h0, 32'h0, 5'b11000});
      @(posedge clk);
      #1;

      // Directed vectors, issued back-to-back.
      issue(4'h0, 32'h7FFF_FFFF, 32'h1);
      issue(4'h1, 32'd5, 32'd3);
      issue(4'h3, 32'd3, 32'd5);
      issue(4'h1, 32'd10, 32'd4);
      issue(4'hD, 32'h8000_0001, 32'd1);
      issue(4'hD, 32'h8000_0001, 32'd0);
      issue(4'h0, 32'hFFFF_FFFF, 32'h1);
      issue(4'hE, 32'd5, 32'd3);
      issue(4'h1, 32'd5, 32'd3);
      issue(4'h4, 32'h7FFF_FFFF, 32'd0);
      issue(4'h5, 32'h8000_0000, 32'd0);
      issue(4'h5, 32'h0, 32'd0);
      issue(4'h6, 32'hFFFF_FFFE, 32'h1);
      issue(4'hB, 32'h0, 32'h0);
      repeat (4) @(posedge clk);
      #1;

      // Stall: out_ready low while 8 ops are offered.
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      n = accept_cnt;
      fork
         for (int i = 0; i < 8; i++) issue(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("stall_accepts", 64'(accept_cnt - n), 64'd2);
            chk("stall_in_ready_low", {63'h0, bif.in_ready}, 64'd0);
            rdy_mode = 1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      chk("stall_drained", 64'(exp_q.size()), 64'd0);

      // Reset with both stages full.
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      issue(4'h0, 32'hFFFF_FFFF, 32'h2);
      issue(4'h9, 32'h1234, 32'h4321);
      @(negedge clk);
      chk("pre_rst_valid", {63'h0, bif.out_valid}, 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      mc = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", {63'h0, bif.out_valid}, 64'd0);
      chk("midrst_in_ready", {63'h0, bif.in_ready}, 64'd1);
      rdy_mode = 1;
      @(posedge clk);
      #1;
      issue(4'h1, 32'd9, 32'd4);   // carry_q cleared by reset, so this gives 5

      // Random stream with random backpressure and gaps.
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         issue(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rdy_mode = 1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("final_drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
